// File: rtl/tmr0_prescaler_sync.sv
// TMR0 tick source: fosc/4 phase, t0clk synchroniser, edge select, 8-bit prescaler.
// Optional macro T0_WRITE_INHIBIT_EN: presc_clr masks inc for two instruction cycles.
module tmr0_prescaler_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       fosc,
  input  logic       mclr_n,
  input  logic       t0clk,
  input  logic       t0cs,
  input  logic       t0se,
  input  logic       psa,
  input  logic [2:0] ps,
  input  logic       presc_clr,
  output logic       inc,
  output logic [7:0] presc_cnt
);

  logic [1:0]             q;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   h;
  logic [2:0]             arm_cnt;
  logic                   armed;
  logic                   int_tick;
  logic                   ext_tick;
  logic                   src_tick;
  logic [7:0]             mask;
  logic                   hit;
  logic                   inh_ok;
  logic                   inc_d;

  assign sync_out = sync[SYNC_STAGES-1];
  assign int_tick = (q == 2'd3);
  assign ext_tick = armed & (t0se ? (~sync_out & h) : (sync_out & ~h));
  assign src_tick = t0cs ? ext_tick : int_tick;
  // ps=0 gives 8'h01, ps=7 gives 8'hFF
  assign mask     = ~(8'hFE << ps);
  assign hit      = psa | ((presc_cnt & mask) == mask);
  // Holding off on the previous inc keeps pulses isolated across source switches
  assign inc_d    = ~presc_clr & src_tick & hit & ~inc & inh_ok;

  // Instruction-cycle phase counter
  always_ff @(posedge fosc or negedge mclr_n) begin
    if (!mclr_n) q <= 2'd0;
    else         q <= q + 2'd1;
  end

  // Pin synchroniser followed by the edge-history flop
  always_ff @(posedge fosc or negedge mclr_n) begin
    if (!mclr_n) begin
      sync <= '0;
      h    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], t0clk};
      h    <= sync_out;
    end
  end

  // Arm external edges only once the synchroniser holds real pin samples
  always_ff @(posedge fosc or negedge mclr_n) begin
    if (!mclr_n) begin
      arm_cnt <= 3'd0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 3'd1;
      armed   <= (arm_cnt == 3'(SYNC_STAGES));
    end
  end

  // Prescaler count; a write clear beats a coincident tick
  always_ff @(posedge fosc or negedge mclr_n) begin
    if (!mclr_n)                presc_cnt <= 8'd0;
    else if (presc_clr)         presc_cnt <= 8'd0;
    else if (src_tick && !psa)  presc_cnt <= presc_cnt + 8'd1;
  end

  // Registered increment strobe
  always_ff @(posedge fosc or negedge mclr_n) begin
    if (!mclr_n) inc <= 1'b0;
    else         inc <= inc_d;
  end

`ifdef T0_WRITE_INHIBIT_EN
  logic [1:0] inh_cnt;

  // Count down two instruction cycles after each TMR0 write
  always_ff @(posedge fosc or negedge mclr_n) begin
    if (!mclr_n)                         inh_cnt <= 2'd0;
    else if (presc_clr)                  inh_cnt <= 2'd2;
    else if (int_tick && inh_cnt != 2'd0) inh_cnt <= inh_cnt - 2'd1;
  end

  assign inh_ok = (inh_cnt == 2'd0);
`else
  assign inh_ok = 1'b1;
`endif

endmodule

// File: doc/tmr0_prescaler_sync.md
TMR0_PRESCALER_SYNC -- requirements
Module: tmr0_prescaler_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on t0clk; legal values 2 or 3.
REQ-002 fosc  input  1  system clock; all state updates on its rising edge.
REQ-003 mclr_n  input  1  reset; asynchronous assert, active-low.
REQ-004 t0clk  input  1  external count pin; asynchronous to fosc.
REQ-005 t0cs  input  1  source select: 0 = internal instruction-cycle tick, 1 = external t0clk edges.
REQ-006 t0se  input  1  external edge select: 0 = rising, 1 = falling.
REQ-007 psa  input  1  1 = prescaler bypassed, 0 = prescaler in path.
REQ-008 ps  input  3  prescale select; ratio = 2^(ps+1), giving 1:2 to 1:256.
REQ-009 presc_clr  input  1  one-cycle strobe issued on a TMR0 write; clears the prescaler.
REQ-010 inc  output  1  one-fosc-cycle pulse; downstream TMR0 increments once per pulse.
REQ-011 presc_cnt  output  8  current prescaler count, for observation.

Function
REQ-012 A 2-bit phase counter q shall count 0,1,2,3,0,... every fosc cycle; the internal tick shall be asserted in each cycle where q==3 (fosc/4).
REQ-013 t0clk shall pass through SYNC_STAGES flops, then one history flop h.
REQ-014 The external tick shall be sync_out & ~h when t0se=0, and ~sync_out & h when t0se=1.
REQ-015 src_tick shall equal the external tick when t0cs=1, otherwise the internal tick.
REQ-016 With SYNC_STAGES=2, an external edge shall produce inc high in the cycle following the 3rd fosc rising edge after the pin change.
REQ-017 External pulses shorter than 2 fosc periods high or low are not guaranteed to be counted.
REQ-018 presc_cnt shall increment by 1, wrapping 255->0, on every src_tick when psa=0; it shall hold when psa=1.
REQ-019 inc is a registered output; with psa=0 it shall be set on a src_tick where (presc_cnt & mask)==mask, with mask = 2^(ps+1)-1.
REQ-020 With psa=1, inc shall be set on every src_tick.
REQ-021 Changes to ps, psa, t0cs and t0se shall take effect on the next cycle without clearing presc_cnt; a possible glitch count on a change is accepted.
REQ-022 presc_clr shall set presc_cnt to 0 on the next edge; if it coincides with src_tick, the clear wins and no inc is produced.
REQ-023 inc shall never be high for two consecutive cycles.

Reset
REQ-024 While mclr_n=0: q, sync flops, h, presc_cnt, inc and all inhibit state shall be 0.
REQ-025 An arm flag, cleared by reset, shall set once the synchroniser has filled (SYNC_STAGES+1 cycles after release). External ticks shall be suppressed until it sets, so that t0clk high at reset never yields a false edge.
REQ-026 Reset asserted mid-count shall discard the partial count; there shall be no inc pulse during reset or on the release cycle.

Configuration
REQ-027 Macro T0_WRITE_INHIBIT_EN: when defined, each presc_clr shall suppress inc for the next 2 internal ticks (two instruction cycles); src_ticks in that window still advance presc_cnt. A new presc_clr within the window restarts it.
REQ-028 When T0_WRITE_INHIBIT_EN is undefined, no inhibit logic shall exist and presc_clr shall only clear presc_cnt.

Verification
REQ-029 t0cs=0, psa=1, after reset -> inc pulses every 4 fosc cycles, first pulse when q first reaches 3.
REQ-030 t0cs=0, psa=0, ps=3'b001 (1:4) -> one inc per 16 fosc cycles; presc_cnt observed stepping 0..3 with inc on the 3->4 transition.
REQ-031 t0cs=1, t0se=0, psa=1, t0clk toggled with a period of 10 fosc cycles -> one inc per rising edge, 3 cycles after each edge; falling edges ignored. Repeat with t0se=1 -> rising edges ignored.
REQ-032 t0clk held at 1 through reset release, t0cs=1 -> no inc until the first genuine edge.
REQ-033 psa=0, ps=3'b111, presc_cnt=8'hFF, with presc_clr and a tick in the same cycle -> presc_cnt=0 and no inc. With T0_WRITE_INHIBIT_EN defined, ps=0, psa=1 -> the next 2 internal ticks after presc_clr give no inc, and the 3rd does.
REQ-034 mclr_n pulsed low for 1 cycle at presc_cnt=8'h5A -> presc_cnt=0 and inc=0 immediately, and counting resumes from 0.
